// File: rtl/window.sv
// Sliding-window builder: shifts incoming pixel columns into a WIDTH_NB-deep
// window and tracks the column/row position within the image. A window is
// marked valid only when every column in it belongs to the current row.
// The last window of each frame is flagged.
module window #(
    parameter int HEIGHT_NB  = 3,
    parameter int WIDTH_NB   = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [MEM_AWIDTH-1:0]                   cfg_width,
    input  logic [MEM_AWIDTH-1:0]                   cfg_height,
    input  logic                                    cfg_set,
    input  logic [IMG_WIDTH*HEIGHT_NB-1:0]          up_data,
    input  logic                                    up_val,
    output logic [IMG_WIDTH*HEIGHT_NB*WIDTH_NB-1:0] dn_data,
    output logic                                    dn_val,
    output logic                                    dn_last
);

    localparam int COL_W = IMG_WIDTH * HEIGHT_NB;
    localparam int WIN_W = COL_W * WIDTH_NB;
    localparam logic [MEM_AWIDTH-1:0] ONE = MEM_AWIDTH'(1);
    localparam logic [MEM_AWIDTH-1:0] WN  = MEM_AWIDTH'(WIDTH_NB);
    localparam logic [MEM_AWIDTH-1:0] HN  = MEM_AWIDTH'(HEIGHT_NB);

    logic [MEM_AWIDTH-1:0] width_q,  width_d;
    logic [MEM_AWIDTH-1:0] height_q, height_d;
    logic                  armed_q,  armed_d;
    logic [MEM_AWIDTH-1:0] col_q,    col_d;
    logic [MEM_AWIDTH-1:0] row_q,    row_d;
    logic [WIN_W-1:0]      win_q,    win_d;
    logic                  val_q,    val_d;
    logic                  last_q,   last_d;

    logic                  beat;
    logic                  col_end;
    logic [MEM_AWIDTH-1:0] row_max;

    // Next-state logic: config capture, window shift and position tracking.
    // cfg_set takes priority over a simultaneous beat, which is dropped.
    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        armed_d  = armed_q;
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        val_d    = 1'b0;
        last_d   = 1'b0;

        beat    = armed_q & up_val & ~cfg_set;
        // Only meaningful while armed, where height_q >= HEIGHT_NB holds.
        row_max = armed_q ? (height_q - HN) : '0;
        col_end = (col_q == (width_q - ONE));

        if (cfg_set) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            armed_d  = (cfg_width >= WN) && (cfg_height >= HN);
            col_d    = '0;
            row_d    = '0;
        end else if (beat) begin
            win_d[COL_W-1:0] = up_data;
            for (int w = 1; w < WIDTH_NB; w++) begin
                win_d[w*COL_W +: COL_W] = win_q[(w-1)*COL_W +: COL_W];
            end
            // The first WIDTH_NB-1 columns of a row still mix in the
            // previous row's pixels, so they produce no window.
            val_d  = (col_q >= (WN - ONE));
            last_d = val_d && col_end && (row_q == row_max);
            if (col_end) begin
                col_d = '0;
                row_d = (row_q == row_max) ? '0 : (row_q + ONE);
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    // State and output registers; reset returns the block to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
            armed_q  <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            val_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            width_q  <= width_d;
            height_q <= height_d;
            armed_q  <= armed_d;
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            val_q    <= val_d;
            last_q   <= last_d;
        end
    end

    assign dn_data = win_q;
    assign dn_val  = val_q;
    assign dn_last = last_q;

endmodule

// File: tb/tb_window.sv
// Testbench for window: directed sequence with random pixel data, checked
// against a frame-position model (beat index within frame, column history).
module tb_window;

    localparam int H  = 3;
    localparam int W  = 3;
    localparam int P  = 8;
    localparam int MA = 16;
    localparam int CW = P * H;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [MA-1:0]    cfg_width = '0;
    logic [MA-1:0]    cfg_height = '0;
    logic             cfg_set = 1'b0;
    logic [CW-1:0]    up_data = '0;
    logic             up_val = 1'b0;
    logic [CW*W-1:0]  dn_data;
    logic             dn_val;
    logic             dn_last;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              m_armed;
    int              m_w, m_h, m_pos;
    logic [CW-1:0]   hist [W];
    logic            exp_val, exp_last;
    logic [CW*W-1:0] exp_data;

    window #(.HEIGHT_NB(H), .WIDTH_NB(W), .IMG_WIDTH(P), .MEM_AWIDTH(MA)) dut (
        .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_set(cfg_set), .up_data(up_data), .up_val(up_val),
        .dn_data(dn_data), .dn_val(dn_val), .dn_last(dn_last)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_armed = 0; m_w = 0; m_h = 0; m_pos = 0;
        for (int i = 0; i < W; i++) hist[i] = '0;
        exp_val = 0; exp_last = 0; exp_data = '0;
    endtask

    task automatic build_data();
        for (int i = 0; i < W; i++) exp_data[i*CW +: CW] = hist[i];
    endtask

    // Model one clock edge from the frame's point of view.
    task automatic model_edge(input logic v, input logic [CW-1:0] d, input logic cs);
        int frame_len;
        exp_val = 0; exp_last = 0;
        if (rst) begin
            model_reset();
        end else if (cs) begin
            m_w = int'(cfg_width); m_h = int'(cfg_height);
            m_armed = (m_w >= W) && (m_h >= H);
            m_pos = 0;
        end else if (m_armed && v) begin
            for (int i = W-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            frame_len = m_w * (m_h - H + 1);
            exp_val  = (m_pos % m_w) >= W-1;
            exp_last = exp_val && (m_pos == frame_len - 1);
            m_pos = (m_pos + 1) % frame_len;
        end
        build_data();
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (dn_val === exp_val) else begin
            errors++;
            $error("FAIL %s dn_val: got %b expected %b", tag, dn_val, exp_val);
        end
        checks++;
        assert (dn_last === exp_last) else begin
            errors++;
            $error("FAIL %s dn_last: got %b expected %b", tag, dn_last, exp_last);
        end
        checks++;
        assert (dn_data === exp_data) else begin
            errors++;
            $error("FAIL %s dn_data: got %h expected %h", tag, dn_data, exp_data);
        end
    endtask

    task automatic step(input logic v, input logic [CW-1:0] d, input logic cs, input string tag);
        up_val = v; up_data = d; cfg_set = cs;
        @(posedge clk);
        model_edge(v, d, cs);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [CW-1:0] pat(input int c);
        logic [CW-1:0] r;
        for (int h = 0; h < H; h++) r[h*P +: P] = P'(16*h + c);
        return r;
    endfunction

    function automatic logic [CW-1:0] rnd();
        return CW'($urandom);
    endfunction

    task automatic configure(input int w, input int h, input string tag);
        cfg_width = MA'(w); cfg_height = MA'(h);
        step(1'b0, '0, 1'b1, tag);
    endtask

    initial begin
        logic [P-1:0] pix;
        model_reset();

        // Reset held with activity on up_val
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0, "reset");
        rst = 1'b0;
        // Idle: no cfg_set yet
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0, "idle");

        // Single row with the 16*h+col pattern
        configure(5, 4, "cfg5x4");
        for (int c = 0; c < 5; c++) begin
            step(1'b1, pat(c), 1'b0, "row0");
            if (c == 2) begin
                pix = dn_data[(0*H+1)*P +: P];
                checks++;
                assert (pix === 8'h12) else begin
                    errors++;
                    $error("FAIL pix10: got %h expected 12", pix);
                end
                pix = dn_data[(2*H+0)*P +: P];
                checks++;
                assert (pix === 8'h00) else begin
                    errors++;
                    $error("FAIL pix02: got %h expected 00", pix);
                end
            end
        end
        // Rest of the frame, then a second full frame
        for (int c = 0; c < 5; c++) step(1'b1, rnd(), 1'b0, "row1");
        for (int c = 0; c < 10; c++) step(1'b1, rnd(), 1'b0, "frame2");

        // Frame with 1-3 idle cycles between beats
        for (int c = 0; c < 10; c++) begin
            step(1'b1, rnd(), 1'b0, "bubble_beat");
            for (int g = 0; g < int'($urandom_range(3, 1)); g++)
                step(1'b0, rnd(), 1'b0, "bubble_idle");
        end

        // cfg_set colliding with beat c3 of row 0
        configure(5, 4, "cfg_again");
        for (int c = 0; c < 3; c++) step(1'b1, rnd(), 1'b0, "pre_collide");
        cfg_width = MA'(5); cfg_height = MA'(4);
        step(1'b1, rnd(), 1'b1, "collide");
        for (int c = 0; c < 3; c++) step(1'b1, rnd(), 1'b0, "post_collide");
        checks++;
        assert (dn_val === 1'b1) else begin
            errors++;
            $error("FAIL collide_third: got %b expected 1", dn_val);
        end

        // Too-narrow image disarms the block
        configure(2, 4, "cfg_narrow");
        for (int c = 0; c < 6; c++) step(1'b1, rnd(), 1'b0, "narrow");

        // Async reset mid-row
        configure(5, 4, "cfg_rst");
        for (int c = 0; c < 4; c++) step(1'b1, rnd(), 1'b0, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) step(1'b1, rnd(), 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/window.md
# window

Sliding-window builder that sits directly downstream of `delay`. Each `up_val` beat carries one column of `HEIGHT_NB` vertically aligned pixels. The block shifts these columns into a `WIDTH_NB`-deep register window and tracks column and row position. It emits a full `HEIGHT_NB` x `WIDTH_NB` window to the filter only when every column belongs to the current image row, and flags the last window of each frame.

## Interface

Parameters:
- `HEIGHT_NB`, 3, window height (lines); matches `delay`
- `WIDTH_NB`, 3, window width (columns)
- `IMG_WIDTH`, 8, bits per pixel
- `MEM_AWIDTH`, 16, width of the configuration fields

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_width`  in  MEM_AWIDTH  image width in pixels
- `cfg_height`  in  MEM_AWIDTH  image height in lines
- `cfg_set`  in  1  latch `cfg_width`/`cfg_height` and restart position tracking
- `up_data`  in  IMG_WIDTH*HEIGHT_NB  one pixel column; slice h=0 is the newest line
- `up_val`  in  1  column valid (the `delay_val` of `delay`)
- `dn_data`  out  IMG_WIDTH*HEIGHT_NB*WIDTH_NB  window; pixel (h,w) at `[(w*HEIGHT_NB+h)*IMG_WIDTH +: IMG_WIDTH]`, w=0 newest column
- `dn_val`  out  1  window valid
- `dn_last`  out  1  last window of frame, qualified by `dn_val`

## Operation

- Config registers: `cfg_width`/`cfg_height` are captured on `cfg_set`. A state flag `armed` is set on `cfg_set` iff width >= WIDTH_NB and height >= HEIGHT_NB; otherwise it is cleared.
- Idle state (`armed`=0): `up_val` is ignored, counters hold 0, and `dn_val`/`dn_last` stay 0.
- Shift: on an accepted beat (`armed` & `up_val` & !`cfg_set`):
  - column 0 <= `up_data`
  - column w <= column w-1, for w = 1..WIDTH_NB-1
  - With no beat, the window holds.
- Column counter `col` (MEM_AWIDTH bits) gives the position of the accepted beat.
  - Increments per beat.
  - At `cfg_width`-1 it wraps to 0 and `row` advances.
- Row counter `row` counts 0..`cfg_height`-HEIGHT_NB, which is the number of rows in which `delay` is valid.
  - Wraps to 0 when `col` wraps at the last row.
- Output valid: `dn_val` asserts for an accepted beat with `col` >= WIDTH_NB-1. The first WIDTH_NB-1 beats of each row are suppressed because the window still holds pixels from the previous row.
- `dn_last` asserts with `dn_val` when `col`=`cfg_width`-1 and `row`=`cfg_height`-HEIGHT_NB.
- Simultaneous `cfg_set` and `up_val`: `cfg_set` wins.
  - The beat is dropped: no shift, no output.
  - `col` and `row` reset to 0.
  - The new config applies from the next cycle.
- `cfg_set` mid-frame: tracking restarts at row 0, column 0. Window contents are left stale, but this is harmless because of the per-row suppression.
- Arithmetic: comparisons are unsigned at MEM_AWIDTH. `cfg_height`-HEIGHT_NB is computed only when armed, so it cannot underflow.

## Timing

- Latency: beat at cycle N gives `dn_data`/`dn_val`/`dn_last` registered at N+1.
- `dn_val` and `dn_last` are single-cycle pulses per beat.
- `dn_data` holds between beats.
- No backpressure; the downstream filter must accept every `dn_val` cycle.
- Reset (async assert, sync deassert) clears to 0:
  - `dn_data`, `dn_val`, `dn_last`
  - `col`, `row`
  - the config registers and `armed`
- Reset mid-frame: the block returns to idle and needs a new `cfg_set`.
- Gaps in `up_val` of any length stall all state without loss.

## Test plan

- Reset and idle: assert `rst` and drive `up_val` before any `cfg_set` -> `dn_val`=0, `dn_last`=0 and `dn_data`=0 throughout.
- Single row, IMG_WIDTH=8, HEIGHT_NB=3, WIDTH_NB=3, `cfg_width`=5, `cfg_height`=4:
  - Stimulus: beats c0..c4 with each slice value = 16*h+col.
  - Required: `dn_val` on the cycles after c2, c3 and c4 only.
  - The first window has w0=c2, w1=c1, w2=c0, e.g. pixel (1,0)=0x12.
- Full frame, same config: 10 beats -> exactly 6 windows, `dn_last` only on the 6th.
  - A second frame repeats identically, confirming wrap-around.
- Bubbles: the frame is fed with 1-3 idle cycles between beats -> the same 6 windows and data as back-to-back, with no `dn_val` on idle cycles.
- Config edge cases:
  - `cfg_set` in the same cycle as beat c3 of row 0 -> the beat is dropped; the next 2 beats produce no output and the 3rd does.
  - `cfg_set` with `cfg_width`=2 -> the block goes idle; later beats produce no `dn_val`.
- Async reset mid-row: pulse `rst` between clock edges after beat c3 -> outputs clear immediately; beats without a new `cfg_set` are ignored.
